// File: rtl/mem_axi_master_if.sv
// Core request/response port and AXI-style bus channels of mem_axi_master.
// The master modport is the bridge's view; the slave modport is the environment's.
interface mem_axi_master_if;
    logic        io_req_valid;
    logic        io_req_ready;
    logic        io_req_wen;
    logic [63:0] io_req_addr;
    logic [63:0] io_req_wdata;
    logic [7:0]  io_req_wstrb;
    logic        io_resp_valid;
    logic [63:0] io_resp_rdata;
    logic        io_resp_err;
    logic [63:0] io_awaddr;
    logic        io_awvalid;
    logic        io_awready;
    logic [63:0] io_wdata;
    logic [7:0]  io_wstrb;
    logic        io_wvalid;
    logic        io_wready;
    logic        io_bvalid;
    logic [63:0] io_araddr;
    logic        io_arvalid;
    logic        io_arready;
    logic [63:0] io_rdata;
    logic        io_rvalid;

    modport master (
        input  io_req_valid, io_req_wen, io_req_addr, io_req_wdata, io_req_wstrb,
        output io_req_ready, io_resp_valid, io_resp_rdata, io_resp_err,
        output io_awaddr, io_awvalid, input io_awready,
        output io_wdata, io_wstrb, io_wvalid, input io_wready,
        input  io_bvalid,
        output io_araddr, io_arvalid, input io_arready,
        input  io_rdata, io_rvalid
    );

    modport slave (
        output io_req_valid, io_req_wen, io_req_addr, io_req_wdata, io_req_wstrb,
        input  io_req_ready, io_resp_valid, io_resp_rdata, io_resp_err,
        input  io_awaddr, io_awvalid, output io_awready,
        input  io_wdata, io_wstrb, io_wvalid, output io_wready,
        output io_bvalid,
        input  io_araddr, io_arvalid, output io_arready,
        output io_rdata, io_rvalid
    );
endinterface

// File: rtl/mem_axi_master.sv
// Single-outstanding bridge from a core request port to AR/R/AW/W/B channels.
// Define AXI_MASTER_TIMEOUT_EN to abort transactions outstanding for TIMEOUT_CYCLES.
module mem_axi_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    mem_axi_master_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;

    state_t      r_state;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic        r_arvalid;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_resp_valid;
    logic [63:0] r_resp_rdata;

    logic w_accept;
    logic w_ar_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_rd_done;
    logic w_wr_done;

    if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("mem_axi_master: TIMEOUT_CYCLES must be at least 2");
    end

    assign w_accept  = bus.io_req_valid && (r_state == S_IDLE);
    assign w_ar_hs   = r_arvalid && bus.io_arready;
    assign w_aw_hs   = r_awvalid && bus.io_awready;
    assign w_w_hs    = r_wvalid && bus.io_wready;
    assign w_rd_done = (r_state == S_R) && bus.io_rvalid;
    assign w_wr_done = (r_state == S_B) && bus.io_bvalid;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] w_tmo_next;
    logic             w_timeout;
    logic             r_resp_err;

    // Abort fires on the edge where the count would reach TIMEOUT_CYCLES-1.
    assign w_tmo_next = r_tmo_cnt + CNT_W'(1);
    assign w_timeout  = (r_state != S_IDLE) && (w_tmo_next == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_IDLE) begin
            r_tmo_cnt <= w_tmo_next;
        end
    end

    assign bus.io_resp_err = r_resp_err;
`else
    assign bus.io_resp_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= bus.io_req_addr;
                        r_wdata <= bus.io_req_wdata;
                        r_wstrb <= bus.io_req_wstrb;
                        if (bus.io_req_wen) begin
                            r_state   <= S_AW_W;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_AR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (bus.io_rvalid) begin
                        r_resp_rdata <= bus.io_rdata;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_AW_W: begin
                    // A dropped valid means that channel's handshake already happened.
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs)  r_wvalid  <= 1'b0;
                    if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (bus.io_bvalid) begin
                        r_resp_valid <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef AXI_MASTER_TIMEOUT_EN
            // A completion landing on the timeout edge takes priority over the abort.
            if (w_timeout && !w_rd_done && !w_wr_done) begin
                r_state      <= S_IDLE;
                r_arvalid    <= 1'b0;
                r_awvalid    <= 1'b0;
                r_wvalid     <= 1'b0;
                r_resp_valid <= 1'b1;
                r_resp_err   <= 1'b1;
                r_resp_rdata <= '0;
            end
`endif
        end
    end

    assign bus.io_req_ready  = (r_state == S_IDLE);
    assign bus.io_resp_valid = r_resp_valid;
    assign bus.io_resp_rdata = r_resp_rdata;
    assign bus.io_araddr     = r_addr;
    assign bus.io_arvalid    = r_arvalid;
    assign bus.io_awaddr     = r_addr;
    assign bus.io_awvalid    = r_awvalid;
    assign bus.io_wdata      = r_wdata;
    assign bus.io_wstrb      = r_wstrb;
    assign bus.io_wvalid     = r_wvalid;

endmodule

// File: tb/tb_mem_axi_master.sv
// Scoreboard bench for mem_axi_master: expected responses are queued at request
// time and popped by a monitor on every io_resp_valid pulse.
module tb_mem_axi_master;
    localparam int TMO = 16;

    logic clock;
    logic reset;

    mem_axi_master_if bus();

    mem_axi_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_rdata = '0;

    always @(negedge clock) begin
        if (reset === 1'b0 && bus.io_resp_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got resp_valid rdata=%h err=%b, expected no response",
                         bus.io_resp_rdata, bus.io_resp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.io_resp_rdata, bus.io_resp_err} !== mon_e) begin
                    n_fail++;
                    $display("FAIL resp_data: got rdata=%h err=%b expected rdata=%h err=%b",
                             bus.io_resp_rdata, bus.io_resp_err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_req_valid = 1'b0;
        bus.io_arready   = 1'b0;
        bus.io_awready   = 1'b0;
        bus.io_wready    = 1'b0;
        bus.io_bvalid    = 1'b0;
        bus.io_rvalid    = 1'b0;
        bus.io_rdata     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.io_req_wen   = 1'b0;
        bus.io_req_addr  = '0;
        bus.io_req_wdata = '0;
        bus.io_req_wstrb = '0;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({bus.io_req_ready, bus.io_arvalid, bus.io_awvalid, bus.io_wvalid,
             bus.io_resp_valid, bus.io_resp_err} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ready/ar/aw/w/resp/err=%b expected 100000",
                     {bus.io_req_ready, bus.io_arvalid, bus.io_awvalid, bus.io_wvalid,
                      bus.io_resp_valid, bus.io_resp_err});
        end
        n_checks++;
        if ({bus.io_resp_rdata, bus.io_araddr, bus.io_awaddr, bus.io_wdata, bus.io_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata=%h araddr=%h awaddr=%h wdata=%h wstrb=%h expected all 0",
                     bus.io_resp_rdata, bus.io_araddr, bus.io_awaddr, bus.io_wdata, bus.io_wstrb);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [63:0] data,
                           input int ar_dly, input int r_dly, input bit spurious);
        int k;
        int rk;
        int cyc;
        int exp_c;
        bit ar_ok;
        bit hs;
        bit got;
        k = 0; rk = 0; cyc = 1; ar_ok = 1'b0; got = 1'b0;
        exp_c = ar_dly + r_dly + 3;
        bus.io_req_valid = 1'b1;
        bus.io_req_wen   = 1'b0;
        bus.io_req_addr  = addr;
        bus.io_req_wdata = {$urandom, $urandom} | 64'h1;
        bus.io_req_wstrb = 8'($urandom) | 8'h1;
        n_checks++;
        if (bus.io_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_req_ready: got %b expected 1", bus.io_req_ready);
        end
        exp_q.push_back('{rdata: data, err: 1'b0});
        last_rdata = data;
        tick();
        bus.io_req_valid = 1'b0;
        while (!got && cyc <= 60) begin
            if (bus.io_resp_valid === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (cyc != exp_c || bus.io_arvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL read_latency: got resp at cycle %0d arvalid=%b expected cycle %0d arvalid=0",
                             cyc, bus.io_arvalid, exp_c);
                end
            end else begin
                n_checks++;
                if (bus.io_arvalid !== !ar_ok || {bus.io_awvalid, bus.io_wvalid} !== 2'b00 ||
                    (!ar_ok && bus.io_araddr !== addr)) begin
                    n_fail++;
                    $display("FAIL read_ar_channel: cycle %0d got arvalid=%b aw/w=%b araddr=%h expected arvalid=%b aw/w=00 araddr=%h",
                             cyc, bus.io_arvalid, {bus.io_awvalid, bus.io_wvalid}, bus.io_araddr, !ar_ok, addr);
                end
                if (!ar_ok) begin
                    bus.io_arready = (k >= ar_dly);
                    bus.io_rvalid  = spurious;
                    bus.io_rdata   = ~data;
                end else begin
                    bus.io_arready = 1'b0;
                    bus.io_rvalid  = (rk >= r_dly);
                    bus.io_rdata   = bus.io_rvalid ? data : ~data;
                    rk++;
                end
                hs = bus.io_arvalid && bus.io_arready;
                k++;
                tick();
                cyc++;
                if (hs) ar_ok = 1'b1;
            end
        end
        idle_inputs();
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_no_resp: got no resp_valid within 60 cycles expected one at cycle %0d", exp_c);
        end
        tick();
        n_checks++;
        if (bus.io_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp_pulse: got resp_valid=%b one cycle later expected 0", bus.io_resp_valid);
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int k;
        int bk;
        int cyc;
        int exp_c;
        bit aw_ok;
        bit w_ok;
        bit aw_hs;
        bit w_hs;
        bit got;
        k = 0; bk = 0; cyc = 1; aw_ok = 1'b0; w_ok = 1'b0; got = 1'b0;
        exp_c = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3;
        bus.io_req_valid = 1'b1;
        bus.io_req_wen   = 1'b1;
        bus.io_req_addr  = addr;
        bus.io_req_wdata = data;
        bus.io_req_wstrb = strb;
        n_checks++;
        if (bus.io_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_req_ready: got %b expected 1", bus.io_req_ready);
        end
        exp_q.push_back('{rdata: last_rdata, err: 1'b0});
        tick();
        bus.io_req_valid = 1'b0;
        while (!got && cyc <= 60) begin
            if (bus.io_resp_valid === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (cyc != exp_c || {bus.io_awvalid, bus.io_wvalid} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL write_latency: got resp at cycle %0d aw/w=%b expected cycle %0d aw/w=00",
                             cyc, {bus.io_awvalid, bus.io_wvalid}, exp_c);
                end
            end else begin
                n_checks++;
                if (bus.io_awvalid !== !aw_ok || bus.io_wvalid !== !w_ok || bus.io_arvalid !== 1'b0 ||
                    (!aw_ok && bus.io_awaddr !== addr) ||
                    (!w_ok && {bus.io_wdata, bus.io_wstrb} !== {data, strb})) begin
                    n_fail++;
                    $display("FAIL write_channels: cycle %0d got aw=%b w=%b ar=%b awaddr=%h wdata=%h wstrb=%h expected aw=%b w=%b ar=0 awaddr=%h wdata=%h wstrb=%h",
                             cyc, bus.io_awvalid, bus.io_wvalid, bus.io_arvalid, bus.io_awaddr, bus.io_wdata,
                             bus.io_wstrb, !aw_ok, !w_ok, addr, data, strb);
                end
                bus.io_awready = (k >= aw_dly);
                bus.io_wready  = (k >= w_dly);
                if (aw_ok && w_ok) begin
                    bus.io_bvalid = (bk >= b_dly);
                    bk++;
                end else begin
                    bus.io_bvalid = 1'b0;
                end
                aw_hs = bus.io_awvalid && bus.io_awready;
                w_hs  = bus.io_wvalid && bus.io_wready;
                k++;
                tick();
                cyc++;
                if (aw_hs) aw_ok = 1'b1;
                if (w_hs)  w_ok  = 1'b1;
            end
        end
        idle_inputs();
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_no_resp: got no resp_valid within 60 cycles expected one at cycle %0d", exp_c);
        end
        tick();
        n_checks++;
        if (bus.io_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_resp_pulse: got resp_valid=%b one cycle later expected 0", bus.io_resp_valid);
        end
    endtask

    task automatic test_read();
        do_read(64'h0000_0000_8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 1'b0);
        do_read(64'h0000_0000_8000_0100, 64'h0123_4567_89AB_CDEF, 2, 3, 1'b0);
        do_read(64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1'b0);
    endtask

    task automatic test_write();
        do_write(64'h0000_0000_8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 0, 3, 1);
        do_write(64'h0000_0000_8000_0020, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0, 0, 0);
        do_write(64'h0000_0000_8000_0028, 64'h0000_0000_0000_0001, 8'hA5, 2, 0, 2);
        do_write(64'h0000_0000_8000_0030, 64'h8000_0000_0000_0000, 8'h81, 1, 1, 0);
    endtask

    // Read then write with req_valid held high and an always-ready slave.
    task automatic test_back_to_back();
        logic [4:0] tbl [7];
        logic [4:0] got_v;
        tbl = '{5'b01000, 5'b00000, 5'b10001, 5'b00110, 5'b00000, 5'b10001, 5'b10000};
        bus.io_arready = 1'b1; bus.io_rvalid = 1'b1; bus.io_rdata = 64'h0BAD_F00D_1234_5678;
        bus.io_awready = 1'b1; bus.io_wready = 1'b1; bus.io_bvalid = 1'b1;
        bus.io_req_valid = 1'b1;
        bus.io_req_wen   = 1'b0;
        bus.io_req_addr  = 64'h0000_0000_9000_0000;
        n_checks++;
        if (bus.io_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_req_ready: got %b expected 1", bus.io_req_ready);
        end
        exp_q.push_back('{rdata: 64'h0BAD_F00D_1234_5678, err: 1'b0});
        last_rdata = 64'h0BAD_F00D_1234_5678;
        tick();
        bus.io_req_wen   = 1'b1;
        bus.io_req_addr  = 64'h0000_0000_9000_0008;
        bus.io_req_wdata = 64'h5555_AAAA_5555_AAAA;
        bus.io_req_wstrb = 8'hF0;
        for (int c = 1; c <= 7; c++) begin
            got_v = {bus.io_req_ready, bus.io_arvalid, bus.io_awvalid, bus.io_wvalid, bus.io_resp_valid};
            n_checks++;
            if (got_v !== tbl[c-1] || (bus.io_arvalid && (bus.io_awvalid || bus.io_wvalid))) begin
                n_fail++;
                $display("FAIL b2b_cycle: cycle %0d got ready/ar/aw/w/resp=%b expected %b",
                         c, got_v, tbl[c-1]);
            end
            if (c == 3) exp_q.push_back('{rdata: last_rdata, err: 1'b0});
            tick();
            if (c == 3) bus.io_req_valid = 1'b0;
        end
        idle_inputs();
    endtask

    task automatic test_spurious();
        bus.io_bvalid = 1'b1;
        tick();
        bus.io_bvalid = 1'b0;
        bus.io_rvalid = 1'b1;
        bus.io_rdata  = 64'hFEED_FACE_FEED_FACE;
        tick();
        bus.io_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({bus.io_resp_valid, bus.io_req_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL spurious_idle: cycle %0d got resp_valid/req_ready=%b expected 01",
                         i, {bus.io_resp_valid, bus.io_req_ready});
            end
            tick();
        end
        do_read(64'h0000_0000_8000_0200, 64'h1357_9BDF_0246_8ACE, 3, 1, 1'b1);
    endtask

    task automatic test_reset_mid_read();
        bus.io_arready = 1'b1;
        bus.io_req_valid = 1'b1;
        bus.io_req_wen   = 1'b0;
        bus.io_req_addr  = 64'h0000_0000_8000_0300;
        bus.io_req_wdata = 64'h7777_6666_5555_4444;
        bus.io_req_wstrb = 8'h3C;
        exp_q.push_back('{rdata: 64'h0, err: 1'b0});
        tick();
        bus.io_req_valid = 1'b0;
        tick();
        n_checks++;
        if ({bus.io_req_ready, bus.io_arvalid, bus.io_resp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_in_r: got ready/ar/resp=%b expected 000",
                     {bus.io_req_ready, bus.io_arvalid, bus.io_resp_valid});
        end
        reset = 1'b1;
        tick();
        exp_q.delete();
        last_rdata = '0;
        n_checks++;
        if ({bus.io_req_ready, bus.io_arvalid, bus.io_awvalid, bus.io_wvalid,
             bus.io_resp_valid, bus.io_resp_err} !== 6'b100000 ||
            {bus.io_resp_rdata, bus.io_araddr, bus.io_wdata, bus.io_wstrb} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got ctrl=%b rdata=%h araddr=%h wdata=%h wstrb=%h expected ctrl=100000 and zero data",
                     {bus.io_req_ready, bus.io_arvalid, bus.io_awvalid, bus.io_wvalid,
                      bus.io_resp_valid, bus.io_resp_err},
                     bus.io_resp_rdata, bus.io_araddr, bus.io_wdata, bus.io_wstrb);
        end
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus.io_resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_no_resp: cycle %0d got resp_valid=%b expected 0", i, bus.io_resp_valid);
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        bit got;
        cnt = 0; got = 1'b0;
        bus.io_req_valid = 1'b1;
        bus.io_req_wen   = 1'b0;
        bus.io_req_addr  = 64'h0000_0000_8000_0400;
`ifdef AXI_MASTER_TIMEOUT_EN
        exp_q.push_back('{rdata: 64'h0, err: 1'b1});
        tick();
        bus.io_req_valid = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (bus.io_resp_valid === 1'b1) got = 1'b1;
            else begin
                if (bus.io_arvalid === 1'b1) cnt++;
                tick();
            end
        end
        last_rdata = '0;
        n_checks++;
        if (!got || cnt != TMO - 1 || {bus.io_arvalid, bus.io_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_abort: got resp=%b arvalid_cycles=%0d ar/ready=%b expected resp=1 cycles=%0d ar/ready=01",
                     got, cnt, {bus.io_arvalid, bus.io_req_ready}, TMO - 1);
        end
        tick();
        n_checks++;
        if (bus.io_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got resp_valid=%b expected 0", bus.io_resp_valid);
        end
        do_read(64'h0000_0000_8000_0408, 64'h2468_ACE0_1357_9BDF, 0, 0, 1'b0);
`else
        tick();
        bus.io_req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if ({bus.io_arvalid, bus.io_resp_valid, bus.io_resp_err} !== 3'b100) begin
                n_fail++;
                $display("FAIL wait_forever: cycle %0d got ar/resp/err=%b expected 100",
                         i, {bus.io_arvalid, bus.io_resp_valid, bus.io_resp_err});
            end
            tick();
        end
        bus.io_arready = 1'b1;
        tick();
        bus.io_arready = 1'b0;
        bus.io_rvalid  = 1'b1;
        bus.io_rdata   = 64'h2468_ACE0_1357_9BDF;
        exp_q.push_back('{rdata: 64'h2468_ACE0_1357_9BDF, err: 1'b0});
        last_rdata = 64'h2468_ACE0_1357_9BDF;
        tick();
        n_checks++;
        if ({bus.io_resp_valid, bus.io_resp_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL wait_complete: got resp/err=%b expected 10", {bus.io_resp_valid, bus.io_resp_err});
        end
        idle_inputs();
        tick();
        cnt = 0;
`endif
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_spurious();
        test_reset_mid_read();
        test_timeout();
        repeat (3) tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_resp: got %0d unanswered requests expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
